// File: rtl/instr_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Instruction fetch controller for the single-cycle MIPS core. Owns the program
// counter, drives the word-addressed instruction ROM, registers each fetched
// word together with its PC and hands it to decode under a stall/redirect
// protocol. Counts delivered instructions (saturating at 16'hFFFF).
//
// Optional feature (compile-time macro FETCH_HALT_DETECT_EN):
//   defined     - a normal capture of HALT_WORD moves the controller to HALT.
//   not defined - HALT_WORD is an ordinary instruction; halted is tied low.
//
// Parameters:
//   RESET_PC   PC loaded on reset (bits [1:0] must be 0)
//   HALT_WORD  instruction word recognised as the branch-to-self halt idiom
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   en             in   run enable (level)
//   stall          in   decode not ready; hold all fetch state
//   redirect_valid in   load redirect_pc this cycle
//   redirect_pc    in   target PC, bits [1:0] ignored
//   imem_addr      out  byte address to ROM (the PC register)
//   imem_rdata     in   ROM word, combinational from imem_addr
//   instr_out      out  registered instruction
//   pc_out         out  PC of instr_out
//   instr_valid    out  instr_out/pc_out hold a live instruction
//   halted         out  controller is in HALT
//   fetch_count    out  instructions delivered, saturating
// ----------------------------------------------------------------------------
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h1000_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HaltDetect = 1'b1;
`else
    localparam bit HaltDetect = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;
    logic [31:0] redirect_target;

    // Masking keeps every redirect_pc bit in use while forcing word alignment.
    assign redirect_target = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0;
            pc_out_q <= 32'h0;
            valid_q  <= 1'b0;
            count_q  <= 16'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (en) state_d = StRun;
            end
            StRun: begin
                if (!en) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end else if (redirect_valid) begin
                    // Word currently on imem_rdata belongs to the old path: drop it.
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                    // The halt word itself is still delivered this cycle.
                    if (HaltDetect && (imem_rdata == HALT_WORD)) state_d = StHalt;
                end
            end
            StHalt: begin
                if (redirect_valid) begin
                    state_d = StRun;
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign fetch_count = count_q;
    assign halted      = HaltDetect && (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl. Expected {pc, word} pairs are pushed
// to a scoreboard queue as fetches are driven and popped when the DUT delivers.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] imem_addr, imem_rdata, instr_out, pc_out;
    logic        instr_valid, halted;
    logic [15:0] fetch_count;

    logic [31:0] imem_addr_w, imem_rdata_w, instr_out_w, pc_out_w;
    logic        instr_valid_w, halted_w;
    logic [15:0] fetch_count_w;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic [63:0] e;
    logic [31:0] mpc;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h00:  rom = 32'h8C08_0000;
            32'h04:  rom = 32'h8C09_0004;
            32'h08:  rom = 32'h0109_5020;
            32'h0C:  rom = 32'hAC0A_0008;
            32'h1C:  rom = 32'h1000_FFFF;
            default: rom = 32'h2000_0000 | a;
        endcase
    endfunction

    assign imem_rdata   = rom(imem_addr);
    assign imem_rdata_w = rom(imem_addr_w);

    instr_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr_out(instr_out),
        .pc_out(pc_out), .instr_valid(instr_valid), .halted(halted),
        .fetch_count(fetch_count)
    );

    instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w), .instr_out(instr_out_w),
        .pc_out(pc_out_w), .instr_valid(instr_valid_w), .halted(halted_w),
        .fetch_count(fetch_count_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({instr_out, pc_out, instr_valid, halted, fetch_count} !== 82'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got instr=%h pc=%h v=%b h=%b cnt=%h want all 0",
                     instr_out, pc_out, instr_valid, halted, fetch_count);
        end
        n_cmp++;
        if (imem_addr !== 32'h0 || imem_addr_w !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL reset_pc: got %h/%h want 00000000/fffffffc", imem_addr, imem_addr_w);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        en = 1'b1;
        tick();
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL idle_to_run: got v=%b addr=%h want 0/00000000", instr_valid, imem_addr);
        end
        mpc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({mpc, rom(mpc)});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (instr_valid !== 1'b1 || pc_out !== e[63:32] || instr_out !== e[31:0]) begin
                n_fail++;
                $display("FAIL seq_fetch%0d: got v=%b pc=%h instr=%h want 1/%h/%h",
                         i, instr_valid, pc_out, instr_out, e[63:32], e[31:0]);
            end
            mpc = mpc + 32'd4;
        end
        n_cmp++;
        if (fetch_count !== 16'd4) begin
            n_fail++;
            $display("FAIL seq_count: got %0d want 4", fetch_count);
        end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        en = 1'b1;
        tick();
        mpc = 32'h0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back({mpc, rom(mpc)});
            tick();
            e = sb.pop_front();
            mpc = mpc + 32'd4;
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (instr_valid !== 1'b1 || pc_out !== e[63:32] || instr_out !== e[31:0] ||
                fetch_count !== 16'd2 || imem_addr !== 32'h8) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h cnt=%0d addr=%h want 1/%h/%h/2/8",
                         i, instr_valid, pc_out, instr_out, fetch_count, imem_addr,
                         e[63:32], e[31:0]);
            end
        end
        stall = 1'b0;
        sb.push_back({mpc, rom(mpc)});
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (instr_valid !== 1'b1 || pc_out !== e[63:32] || instr_out !== e[31:0]) begin
            n_fail++;
            $display("FAIL stall_resume: got v=%b pc=%h instr=%h want 1/%h/%h",
                     instr_valid, pc_out, instr_out, e[63:32], e[31:0]);
        end
        // Redirect with concurrent stall: redirect wins, bubble, then target word.
        redirect_valid = 1'b1; redirect_pc = 32'h0000_000E; stall = 1'b1;
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'hC || fetch_count !== 16'd3) begin
            n_fail++;
            $display("FAIL redirect_bubble: got v=%b addr=%h cnt=%0d want 0/0000000c/3",
                     instr_valid, imem_addr, fetch_count);
        end
        sb.push_back({32'hC, rom(32'hC)});
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (instr_valid !== 1'b1 || pc_out !== e[63:32] || instr_out !== e[31:0]) begin
            n_fail++;
            $display("FAIL redirect_target: got v=%b pc=%h instr=%h want 1/%h/%h",
                     instr_valid, pc_out, instr_out, e[63:32], e[31:0]);
        end
    endtask

    task automatic test_halt();
        do_reset();
        en = 1'b1;
        tick();
        mpc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back({mpc, rom(mpc)});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (instr_valid !== 1'b1 || pc_out !== e[63:32] || instr_out !== e[31:0]) begin
                n_fail++;
                $display("FAIL halt_run%0d: got v=%b pc=%h instr=%h want 1/%h/%h",
                         i, instr_valid, pc_out, instr_out, e[63:32], e[31:0]);
            end
            mpc = mpc + 32'd4;
        end
`ifdef FETCH_HALT_DETECT_EN
        n_cmp++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_rise: got halted=%b want 1", halted);
        end
        tick();
        n_cmp++;
        if (instr_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL halt_hold: got v=%b h=%b addr=%h want 0/1/00000020",
                     instr_valid, halted, imem_addr);
        end
        en = 1'b0;
        tick();
        n_cmp++;
        if (halted !== 1'b1 || imem_addr !== 32'h20) begin
            n_fail++;
            $display("FAIL halt_en_ignored: got h=%b addr=%h want 1/00000020", halted, imem_addr);
        end
        en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        n_cmp++;
        if (halted !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL halt_exit: got h=%b v=%b addr=%h want 0/0/00000000",
                     halted, instr_valid, imem_addr);
        end
        sb.push_back({32'h0, rom(32'h0)});
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (instr_valid !== 1'b1 || pc_out !== e[63:32] || instr_out !== e[31:0]) begin
            n_fail++;
            $display("FAIL halt_refetch: got v=%b pc=%h instr=%h want 1/%h/%h",
                     instr_valid, pc_out, instr_out, e[63:32], e[31:0]);
        end
`else
        sb.push_back({mpc, rom(mpc)});
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (halted !== 1'b0 || instr_valid !== 1'b1 || pc_out !== e[63:32] ||
            imem_addr !== 32'h24) begin
            n_fail++;
            $display("FAIL no_halt: got h=%b v=%b pc=%h addr=%h want 0/1/%h/00000024",
                     halted, instr_valid, pc_out, imem_addr, e[63:32]);
        end
`endif
    endtask

    task automatic test_wrap_async_reset();
        do_reset();
        en = 1'b1;
        tick();
        mpc = 32'hFFFF_FFFC;
        for (int i = 0; i < 2; i++) begin
            sb.push_back({mpc, rom(mpc)});
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (instr_valid_w !== 1'b1 || pc_out_w !== e[63:32] || instr_out_w !== e[31:0]) begin
                n_fail++;
                $display("FAIL wrap_fetch%0d: got v=%b pc=%h instr=%h want 1/%h/%h",
                         i, instr_valid_w, pc_out_w, instr_out_w, e[63:32], e[31:0]);
            end
            mpc = mpc + 32'd4;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({instr_out_w, pc_out_w, instr_valid_w, fetch_count_w} !== 81'h0 ||
            imem_addr_w !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got instr=%h pc=%h v=%b cnt=%h addr=%h want 0/0/0/0/fffffffc",
                     instr_out_w, pc_out_w, instr_valid_w, fetch_count_w, imem_addr_w);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (instr_valid_w !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_to_idle: got v=%b want 0", instr_valid_w);
        end
        tick();
        n_cmp++;
        if (instr_valid_w !== 1'b1 || pc_out_w !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL restart: got v=%b pc=%h want 1/fffffffc", instr_valid_w, pc_out_w);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        en = 1'b1;
        tick();
        // Run from 0x100 so the halt word at 0x1C is never fetched.
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 65534; i++) tick();
        n_cmp++;
        if (fetch_count !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_pre: got %h want fffe", fetch_count);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (fetch_count !== 16'hFFFF || instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_hold%0d: got cnt=%h v=%b want ffff/1", i, fetch_count, instr_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_halt();
        test_wrap_async_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
